// File: rtl/lsu_dmem_if_if.sv
// Request/response bus between the execute stage (master) and the load/store unit (slave).
interface lsu_dmem_if_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lsu_dmem_if.sv
// Load/store unit: one request at a time, word-aligned dmem accesses, lane steering and load extension.
// Define MISALIGNED_SPLIT_EN to split word-crossing accesses into two dmem accesses instead of erroring.
module lsu_dmem_if #(
    parameter int DMEM_BYTES = 16384,
    parameter int RD_LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    lsu_dmem_if_if.slave bus,
    output logic         mem_we,
    output logic [3:0]   mem_wmask,
    output logic [31:0]  mem_addr,
    output logic [31:0]  mem_wdata,
    input  logic [31:0]  mem_rdata
);

    localparam bit REG_READ = (RD_LATENCY != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE0,
        S_CAPT0,
        S_ISSUE1,
        S_CAPT1,
        S_RESP
    } state_t;

    state_t state, state_d;

    logic [1:0]  req_off;
    logic [2:0]  req_bytes;
    logic        req_cross;
    logic [32:0] req_last;
    logic        req_oor;
    logic [1:0]  req_err;
`ifdef MISALIGNED_SPLIT_EN
    logic        req_split;
`endif

    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        split_q;
    logic [31:0] w0_q;
    logic [31:0] w1_q;
    logic [31:0] rsp_rdata_q;
    logic [1:0]  rsp_err_q;

    logic        accept;
    logic        ready_c;
    logic        issue;
    logic        second;
    logic [1:0]  off_q;
    logic [3:0]  smask_q;
    logic [7:0]  wmask8;
    logic [63:0] wdata64;
    logic        cap0;
    logic        cap1;
    logic [31:0] w0_cur;
    logic [31:0] w1_cur;
    logic [31:0] ld_word;
    logic [31:0] ld_ext;

    function automatic logic [31:0] extend_load(input logic [31:0] w, input logic [1:0] size,
                                                input logic uns);
        logic [31:0] r;
        case (size)
            2'b00:   r = uns ? {24'd0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
            2'b01:   r = uns ? {16'd0, w[15:0]} : {{16{w[15]}}, w[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    // Classify the incoming request; the range check uses 33 bits so the last byte never wraps.
    always_comb begin
        req_off = bus.req_addr[1:0];
        case (bus.req_size)
            2'b00:   req_bytes = 3'd1;
            2'b01:   req_bytes = 3'd2;
            default: req_bytes = 3'd4;
        endcase
        req_cross = ({1'b0, req_off} + req_bytes) > 3'd4;
        req_last  = {1'b0, bus.req_addr} + {30'd0, req_bytes} - 33'd1;
        req_oor   = req_last >= 33'(DMEM_BYTES);
`ifdef MISALIGNED_SPLIT_EN
        req_split = req_cross;
        req_err   = req_oor ? 2'b10 : 2'b00;
`else
        if (req_cross || (bus.req_size == 2'b01 && req_off[0]) ||
            (bus.req_size[1] && req_off != 2'b00))
            req_err = 2'b01;
        else if (req_oor)
            req_err = 2'b10;
        else
            req_err = 2'b00;
`endif
    end

    always_comb begin
        off_q = addr_q[1:0];
        case (size_q)
            2'b00:   smask_q = 4'b0001;
            2'b01:   smask_q = 4'b0011;
            default: smask_q = 4'b1111;
        endcase
        wmask8  = {4'b0000, smask_q} << off_q;
        wdata64 = {32'd0, wdata_q} << {off_q, 3'b000};
        second  = (state == S_ISSUE1) || (state == S_CAPT1);
    end

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        ready_c = 1'b0;
        issue   = 1'b0;
        case (state)
            S_IDLE: begin
                ready_c = 1'b1;
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    state_d = (req_err != 2'b00) ? S_RESP : S_ISSUE0;
                end
            end
            S_ISSUE0: begin
                issue = 1'b1;
                if (!we_q && REG_READ)
                    state_d = S_CAPT0;
                else
                    state_d = split_q ? S_ISSUE1 : S_RESP;
            end
            S_CAPT0: state_d = split_q ? S_ISSUE1 : S_RESP;
`ifdef MISALIGNED_SPLIT_EN
            S_ISSUE1: begin
                issue   = 1'b1;
                state_d = (!we_q && REG_READ) ? S_CAPT1 : S_RESP;
            end
            S_CAPT1: state_d = S_RESP;
`endif
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // dmem port is decoded straight from state so a reset drops mem_we without waiting for a clock.
    assign mem_we    = issue & we_q;
    assign mem_wmask = mem_we ? (second ? wmask8[7:4] : wmask8[3:0]) : 4'b0000;
    assign mem_addr  = {addr_q[31:2] + {29'd0, second}, 2'b00};
    assign mem_wdata = second ? wdata64[63:32] : wdata64[31:0];

    always_comb begin
        cap0    = !we_q && (REG_READ ? (state == S_CAPT0) : (state == S_ISSUE0));
        cap1    = !we_q && (REG_READ ? (state == S_CAPT1) : (state == S_ISSUE1));
        w0_cur  = cap0 ? mem_rdata : w0_q;
        w1_cur  = cap1 ? mem_rdata : w1_q;
        ld_word = 32'({w1_cur, w0_cur} >> {off_q, 3'b000});
        ld_ext  = extend_load(ld_word, size_q, uns_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else if (accept) begin
            we_q    <= bus.req_we;
            size_q  <= bus.req_size;
            uns_q   <= bus.req_unsigned;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
    end

`ifdef MISALIGNED_SPLIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            split_q <= 1'b0;
        else if (accept)
            split_q <= req_split;
    end
`else
    assign split_q = 1'b0;
`endif

    // The upper word stays zero unless a second access refills it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w0_q <= 32'd0;
            w1_q <= 32'd0;
        end else if (accept) begin
            w0_q <= 32'd0;
            w1_q <= 32'd0;
        end else begin
            if (cap0)
                w0_q <= mem_rdata;
            if (cap1)
                w1_q <= mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 2'b00;
        end else if (accept && req_err != 2'b00) begin
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= req_err;
        end else if (state != S_IDLE && state != S_RESP && state_d == S_RESP) begin
            rsp_rdata_q <= we_q ? 32'd0 : ld_ext;
            rsp_err_q   <= 2'b00;
        end
    end

    assign bus.req_ready = ready_c;
    assign bus.rsp_valid = (state == S_RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule
